// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the 5-stage RV32I core.
// Holds the hazard-sequencer state encoding, the major opcodes ID decodes to
// produce ex_is_load / id_use_rs*, and the canonical NOP (addi x0,x0,0).
package pipe_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [31:0] NOP_INSN  = 32'h00000013;

  // True when an opcode leaves the pipeline on a (possibly) redirected path.
  function automatic logic is_ctrl_xfer(input logic [6:0] op);
    return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
// Ports:
//   clk    - clock
//   i_clr  - synchronous clear (wins over enable)
//   i_en   - count enable
//   o_cnt  - current count; sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (i_clr)                      r_cnt <= '0;
    else if (i_en && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Central stall/flush sequencer for the IF/ID/EX/MEM/WB pipeline.
// Control outputs are combinational from the current state and inputs so the
// pipeline registers react in the same cycle a hazard appears.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   id_rs1/id_rs2         - source register fields of the instruction in ID
//   id_use_rs1/id_use_rs2 - ID instruction actually reads that source
//   ex_rd/ex_is_load/ex_reg_write - producer info held in ID/EX
//   ex_br_taken           - taken branch/jump resolved in EX this cycle
//   ex_busy / mem_busy    - multi-cycle EX unit / data memory not ready
//   pc_en, *_en, *_flush  - pipeline register load enables and bubble inserts
//   stall_cnt / flush_cnt - saturating counts of pc_en=0 / if_id_flush=1 cycles
//   hang_err              - sticky: freeze lasted HANG_LIMIT consecutive cycles
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int BR_PENALTY = 2,
  parameter int HANG_LIMIT = 1024,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_reg_write,
  input  logic             ex_br_taken,
  input  logic             ex_busy,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             ex_mem_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             hang_err
);

  localparam logic [1:0]     FC_RELOAD = 2'(BR_PENALTY - 1);
  localparam int             FRZ_W     = $clog2(HANG_LIMIT + 1);
  localparam logic [FRZ_W-1:0] FRZ_MAX  = FRZ_W'(HANG_LIMIT);
  localparam logic [FRZ_W-1:0] FRZ_LAST = FRZ_W'(HANG_LIMIT - 1);

  state_e           r_state;
  logic [1:0]       r_fcnt;   // flush cycles still owed after this one
  logic [FRZ_W-1:0] r_frz;    // consecutive frozen cycles
  logic             r_hang;

  logic w_lu, w_frozen, w_flush_now, w_stall_en;

  assign w_lu = ex_is_load & ex_reg_write & (ex_rd != 5'd0) &
                ((id_use_rs1 & (id_rs1 == ex_rd)) |
                 (id_use_rs2 & (id_rs2 == ex_rd)));
  assign w_frozen    = mem_busy | ex_busy;
  assign w_flush_now = ex_br_taken | (r_state == ST_FLUSH);

  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b0;
    ex_mem_flush = 1'b0;
    if (rst || mem_busy) begin
      // full freeze: every register holds
    end else if (ex_busy) begin
      // front end holds, EX/MEM takes bubbles while the unit grinds
      ex_mem_en    = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (w_flush_now) begin
      // wrong-path squash; a load-use on a squashed instruction is moot
      pc_en       = 1'b1;
      if_id_en    = 1'b1;
      if_id_flush = 1'b1;
      id_ex_en    = 1'b1;
      id_ex_flush = 1'b1;
      ex_mem_en   = 1'b1;
    end else if (w_lu) begin
      // hold IF/ID, push a bubble into EX; the load moves on next cycle
      id_ex_en    = 1'b1;
      id_ex_flush = 1'b1;
      ex_mem_en   = 1'b1;
    end else begin
      pc_en     = 1'b1;
      if_id_en  = 1'b1;
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_fcnt  <= 2'd0;
    end else if (!w_frozen) begin
      if (ex_br_taken) begin
        if (BR_PENALTY > 1) begin
          r_state <= ST_FLUSH;
          r_fcnt  <= FC_RELOAD;
        end else begin
          r_state <= ST_RUN;
          r_fcnt  <= 2'd0;
        end
      end else if (r_state == ST_FLUSH) begin
        if (r_fcnt <= 2'd1) begin
          r_state <= ST_RUN;
          r_fcnt  <= 2'd0;
        end else begin
          r_fcnt  <= r_fcnt - 2'd1;
        end
      end
    end
  end

  // Watchdog: counter saturates, flag is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frz  <= '0;
      r_hang <= 1'b0;
    end else if (w_frozen) begin
      if (r_frz < FRZ_MAX) r_frz <= r_frz + 1'b1;
      if (r_frz >= FRZ_LAST) r_hang <= 1'b1;
    end else begin
      r_frz <= '0;
    end
  end

  assign hang_err   = r_hang;
  assign w_stall_en = ~rst & ~pc_en;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .i_clr (rst),
    .i_en  (w_stall_en),
    .o_cnt (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .i_clr (rst),
    .i_en  (if_id_flush),
    .o_cnt (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: each step pushes its expected control word
// or counter values into a scoreboard queue, which is drained and compared
// once the DUT outputs have settled for that step.
module tb_hazard_ctrl;
  localparam int BR_PENALTY = 2;
  localparam int HANG_LIMIT = 8;
  localparam int CNT_W      = 4;   // small so saturation is reachable

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_use_rs1, id_use_rs2, ex_is_load, ex_reg_write;
  logic ex_br_taken, ex_busy, mem_busy;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic hang_err;

  hazard_ctrl #(.BR_PENALTY(BR_PENALTY), .HANG_LIMIT(HANG_LIMIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_reg_write(ex_reg_write),
    .ex_br_taken(ex_br_taken), .ex_busy(ex_busy), .mem_busy(mem_busy),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
    .ex_mem_en(ex_mem_en), .ex_mem_flush(ex_mem_flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .hang_err(hang_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic rst; logic [4:0] rs1, rs2; logic u1, u2; logic [4:0] rd;
    logic ld, rw, br, exb, memb;
  } stim_t;

  typedef struct {
    string       tag;
    int          kind;   // 0 ctl word, 1 stall_cnt, 2 flush_cnt, 3 hang_err
    logic [31:0] val;
  } exp_t;

  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush}
  localparam logic [6:0] C_RUN = 7'b1101010;
  localparam logic [6:0] C_OFF = 7'b0000000;
  localparam logic [6:0] C_EXB = 7'b0000011;
  localparam logic [6:0] C_BR  = 7'b1111110;
  localparam logic [6:0] C_LU  = 7'b0001110;

  exp_t sbq[$];
  int npass = 0;
  int ntotal = 0;

  task automatic apply(input stim_t s);
    rst = s.rst; id_rs1 = s.rs1; id_rs2 = s.rs2; id_use_rs1 = s.u1; id_use_rs2 = s.u2;
    ex_rd = s.rd; ex_is_load = s.ld; ex_reg_write = s.rw;
    ex_br_taken = s.br; ex_busy = s.exb; mem_busy = s.memb;
  endtask

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      0:       return {25'd0, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush};
      1:       return 32'(stall_cnt);
      2:       return 32'(flush_cnt);
      default: return {31'd0, hang_err};
    endcase
  endfunction

  task automatic drain();
    exp_t e;
    logic [31:0] o;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      o = observe(e.kind);
      ntotal++;
      assert (o === e.val) npass++;
      else $error("FAIL %s(kind %0d): observed %0h expected %0h", e.tag, e.kind, o, e.val);
    end
  endtask

  // One clock cycle of stimulus with its expected combinational control word.
  task automatic cyc(input string tag, input stim_t s, input logic [6:0] ectl);
    @(negedge clk);
    apply(s);
    sbq.push_back('{tag, 0, 32'(ectl)});
    #1 drain();
  endtask

  // Counter/flag values after the edge that closes the last cyc().
  task automatic expect_cnt(input string tag, input int st, input int fl, input int hg);
    @(posedge clk);
    #1;
    sbq.push_back('{{tag, "_stall"}, 1, 32'(st)});
    sbq.push_back('{{tag, "_flush"}, 2, 32'(fl)});
    sbq.push_back('{{tag, "_hang"},  3, 32'(hg)});
    drain();
  endtask

  initial begin
    stim_t idle, s;
    idle = '0;
    s = idle; s.rst = 1'b1;
    apply(s);

    // reset: everything disabled, counters clear
    cyc("rst0", s, C_OFF);
    cyc("rst1", s, C_OFF);
    expect_cnt("after_rst", 0, 0, 0);

    // load-use via rs1, then hazard gone
    s = idle; s.ld = 1; s.rw = 1; s.rd = 5'd5; s.u1 = 1; s.rs1 = 5'd5;
    cyc("lu_rs1", s, C_LU);
    expect_cnt("lu_rs1", 1, 0, 0);
    cyc("lu_clear", idle, C_RUN);

    // load-use via rs2
    s = idle; s.ld = 1; s.rw = 1; s.rd = 5'd7; s.u2 = 1; s.rs2 = 5'd7;
    cyc("lu_rs2", s, C_LU);
    // not a load / no writeback / operand not read: no hazard
    s.ld = 0;                  cyc("nolu_alu", s, C_RUN);
    s.ld = 1; s.rw = 0;        cyc("nolu_norw", s, C_RUN);
    s.rw = 1; s.u2 = 0;        cyc("nolu_nouse", s, C_RUN);
    // load to x0 never stalls
    s = idle; s.ld = 1; s.rw = 1; s.rd = 5'd0; s.u1 = 1; s.rs1 = 5'd0;
    cyc("lu_x0", s, C_RUN);
    expect_cnt("lu_x0", 2, 0, 0);

    // taken branch with a simultaneous load-use: branch wins, 2 flush cycles
    s = idle; s.br = 1; s.ld = 1; s.rw = 1; s.rd = 5'd3; s.u1 = 1; s.rs1 = 5'd3;
    cyc("br0", s, C_BR);
    cyc("br1", idle, C_BR);
    cyc("br_done", idle, C_RUN);
    expect_cnt("br", 2, 2, 0);

    // branch, then mem_busy freezes the remaining flush cycle
    s = idle; s.br = 1;
    cyc("brm0", s, C_BR);
    s = idle; s.memb = 1;
    for (int i = 0; i < 3; i++) cyc("brm_frz", s, C_OFF);
    cyc("brm1", idle, C_BR);
    cyc("brm_done", idle, C_RUN);
    expect_cnt("brm", 5, 4, 0);

    // second branch inside FLUSH reloads the count
    s = idle; s.br = 1;
    cyc("brr0", s, C_BR);
    cyc("brr1", s, C_BR);
    cyc("brr2", idle, C_BR);
    cyc("brr_done", idle, C_RUN);
    expect_cnt("brr", 5, 7, 0);

    // 5-cycle EX op: below the watchdog limit
    s = idle; s.exb = 1;
    for (int i = 0; i < 5; i++) cyc("exb5", s, C_EXB);
    expect_cnt("exb5", 10, 7, 0);
    cyc("exb5_done", idle, C_RUN);

    // ex_busy during FLUSH holds the state
    s = idle; s.br = 1;
    cyc("bre0", s, C_BR);
    s = idle; s.exb = 1;
    cyc("bre_exb", s, C_EXB);
    cyc("bre1", idle, C_BR);
    cyc("bre_done", idle, C_RUN);
    expect_cnt("bre", 11, 9, 0);

    // mem_busy outranks ex_busy
    s = idle; s.exb = 1; s.memb = 1;
    cyc("mem_over_ex", s, C_OFF);
    cyc("moe_done", idle, C_RUN);

    // 8-cycle EX op trips the watchdog; stall_cnt saturates at 15
    s = idle; s.exb = 1;
    for (int i = 0; i < 8; i++) cyc("exb8", s, C_EXB);
    expect_cnt("exb8", 15, 9, 1);
    cyc("exb8_done", idle, C_RUN);
    s = idle; s.ld = 1; s.rw = 1; s.rd = 5'd9; s.u1 = 1; s.rs1 = 5'd9;
    cyc("lu_sat", s, C_LU);
    expect_cnt("sticky", 15, 9, 1);

    // reset in the middle of FLUSH abandons it
    s = idle; s.br = 1;
    cyc("brx0", s, C_BR);
    s = idle; s.rst = 1;
    cyc("brx_rst", s, C_OFF);
    expect_cnt("brx_rst", 0, 0, 0);
    cyc("brx_after", idle, C_RUN);
    expect_cnt("brx_after", 0, 0, 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
